// File: rtl/dpll_seq_pkg.sv
// Shared state encoding, default timing constants and the window-qualification helper
// for the DPLL lock sequencer.
package dpll_seq_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StReset   = 3'd1,
      StSettle  = 3'd2,
      StAcquire = 3'd3,
      StLocked  = 3'd4,
      StFail    = 3'd5
   } seq_state_e;

   localparam int unsigned DefWinLog2   = 8;
   localparam int unsigned DefFbExp     = 16;
   localparam int unsigned DefFbTol     = 1;
   localparam int unsigned DefRstCyc    = 16;
   localparam int unsigned DefSettleCyc = 1024;
   localparam int unsigned DefLockN     = 4;
   localparam int unsigned DefMaxTry    = 64;

   // A window is good when its edge count lies within expv +/- tol.
   function automatic logic is_good(input logic [7:0] cnt, input int unsigned expv,
                                    input int unsigned tol);
      int unsigned c;
      c = 32'(cnt);
      if (c >= expv) return (c - expv) <= tol;
      return (expv - c) <= tol;
   endfunction

endpackage

// File: rtl/dpll_freq_meter.sv
// Counts synchronised fb_tgl edges over a fixed window of reference clocks.
// win_done/win_cnt are combinational in the terminal cycle of each window.
module dpll_freq_meter
   import dpll_seq_pkg::*;
#(
   parameter int unsigned WinLog2 = DefWinLog2
) (
   input  logic       clock,
   input  logic       resetb,
   input  logic       run,
   input  logic       fb_tgl,
   output logic       win_done,
   output logic [7:0] win_cnt
);

   logic               sync1_q, sync2_q, sync3_q;
   logic               fb_edge;
   logic [WinLog2-1:0] win_q, win_d;
   logic [7:0]         edge_q, edge_d;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         win_q   <= '0;
         edge_q  <= '0;
      end else begin
         sync1_q <= fb_tgl;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         win_q   <= win_d;
         edge_q  <= edge_d;
      end
   end

   assign fb_edge  = sync2_q ^ sync3_q;
   assign win_done = run && (win_q == '1);

   always_comb begin
      // Final count includes an edge landing in the terminal cycle; saturates at 255.
      win_cnt = (edge_q == 8'hff) ? 8'hff : edge_q + {7'd0, fb_edge};
      win_d   = win_q + WinLog2'(1);
      edge_d  = win_cnt;
      if (!run) begin
         win_d  = '0;
         edge_d = '0;
      end else if (win_done) begin
         edge_d = '0;
      end
   end

endmodule

// File: rtl/dpll_lock_sequencer.sv
// Power-up, lock qualification and clock-switchover sequencer for the dpll instance.
// All control outputs are registered decodes of the next state.
module dpll_lock_sequencer
   import dpll_seq_pkg::*;
#(
   parameter int unsigned WinLog2   = DefWinLog2,
   parameter int unsigned FbExp     = DefFbExp,
   parameter int unsigned FbTol     = DefFbTol,
   parameter int unsigned RstCyc    = DefRstCyc,
   parameter int unsigned SettleCyc = DefSettleCyc,
   parameter int unsigned LockN     = DefLockN,
   parameter int unsigned MaxTry    = DefMaxTry
) (
   input  logic       clock,
   input  logic       resetb,
   input  logic       cfg_enable,
   input  logic [4:0] cfg_div,
   input  logic       fb_tgl,
   output logic       pll_resetb,
   output logic       pll_enable,
   output logic [4:0] pll_div,
   output logic       sel_pll,
   output logic       locked,
   output logic       fail,
   output logic       lock_lost,
   output logic [7:0] meas_cnt,
   output logic [2:0] state
);

   localparam int unsigned TmrW  = $clog2((SettleCyc > RstCyc) ? SettleCyc : RstCyc) + 1;
   localparam int unsigned GoodW = $clog2(LockN + 1);
   localparam int unsigned TryW  = $clog2(MaxTry + 1);

   seq_state_e       state_q, state_d;
   logic [TmrW-1:0]  tmr_q, tmr_d;
   logic [GoodW-1:0] good_q, good_d;
   logic [TryW-1:0]  try_q, try_d;
   logic [4:0]       div_q, div_d;
   logic             lost_q, lost_d;
   logic [7:0]       meas_q, meas_d;
   logic             rstb_q, rstb_d, en_q, en_d, sel_q, sel_d, fail_q, fail_d;

   logic             run, win_done, win_good, div_change;
   logic [7:0]       win_cnt;

   assign run = (state_q == StAcquire) || (state_q == StLocked);

   dpll_freq_meter #(
      .WinLog2 (WinLog2)
   ) u_meter (
      .clock    (clock),
      .resetb   (resetb),
      .run      (run),
      .fb_tgl   (fb_tgl),
      .win_done (win_done),
      .win_cnt  (win_cnt)
   );

   assign win_good   = is_good(win_cnt, FbExp, FbTol);
   assign div_change = (cfg_div != div_q);

   always_comb begin
      state_d = state_q;
      tmr_d   = '0;
      good_d  = good_q;
      try_d   = try_q;
      div_d   = div_q;
      lost_d  = lost_q;
      meas_d  = win_done ? win_cnt : meas_q;

      if ((state_q != StIdle) && !cfg_enable) begin
         state_d = StIdle;
      end else if (((state_q == StSettle) || (state_q == StAcquire) || (state_q == StLocked))
                   && div_change) begin
         state_d = StReset;
         div_d   = cfg_div;
         lost_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cfg_enable) begin
                  state_d = StReset;
                  div_d   = cfg_div;
                  lost_d  = 1'b0;
               end
            end
            StReset: begin
               if (tmr_q == TmrW'(RstCyc - 1)) state_d = StSettle;
               else tmr_d = tmr_q + TmrW'(1);
            end
            StSettle: begin
               if (tmr_q == TmrW'(SettleCyc - 1)) begin
                  state_d = StAcquire;
                  good_d  = '0;
                  try_d   = '0;
               end else begin
                  tmr_d = tmr_q + TmrW'(1);
               end
            end
            StAcquire: begin
               if (win_done) begin
                  good_d = win_good ? good_q + GoodW'(1) : '0;
                  try_d  = try_q + TryW'(1);
                  // Lock wins over timeout when both land on the same window.
                  if (good_d == GoodW'(LockN)) state_d = StLocked;
                  else if (try_d == TryW'(MaxTry)) state_d = StFail;
               end
            end
            StLocked: begin
               if (win_done && !win_good) begin
                  state_d = StAcquire;
                  good_d  = '0;
                  try_d   = '0;
                  lost_d  = 1'b1;
               end
            end
            StFail: ;
            default: state_d = StIdle;
         endcase
      end

      en_d   = (state_d == StReset) || (state_d == StSettle) ||
               (state_d == StAcquire) || (state_d == StLocked);
      rstb_d = (state_d == StSettle) || (state_d == StAcquire) || (state_d == StLocked);
      sel_d  = (state_d == StLocked);
      fail_d = (state_d == StFail);
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q <= StIdle;
         tmr_q   <= '0;
         good_q  <= '0;
         try_q   <= '0;
         div_q   <= '0;
         lost_q  <= 1'b0;
         meas_q  <= '0;
         rstb_q  <= 1'b0;
         en_q    <= 1'b0;
         sel_q   <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         good_q  <= good_d;
         try_q   <= try_d;
         div_q   <= div_d;
         lost_q  <= lost_d;
         meas_q  <= meas_d;
         rstb_q  <= rstb_d;
         en_q    <= en_d;
         sel_q   <= sel_d;
         fail_q  <= fail_d;
      end
   end

   assign pll_resetb = rstb_q;
   assign pll_enable = en_q;
   assign pll_div    = div_q;
   assign sel_pll    = sel_q;
   assign locked     = sel_q;
   assign fail       = fail_q;
   assign lock_lost  = lost_q;
   assign meas_cnt   = meas_q;
   assign state      = state_q;

endmodule

// File: tb/tb_dpll_lock_sequencer.sv
// Directed bench for dpll_lock_sequencer; fb_tgl edges are placed inside known
// 256-cycle windows so each window count is exact.
module tb_dpll_lock_sequencer;

   logic       clock = 1'b0;
   logic       resetb, cfg_enable, fb_tgl;
   logic [4:0] cfg_div;
   logic       pll_resetb, pll_enable, sel_pll, locked, fail, lock_lost;
   logic [4:0] pll_div;
   logic [7:0] meas_cnt;
   logic [2:0] state;
   logic [5:0] flags;

   int tests = 0;
   int errors = 0;

   dpll_lock_sequencer dut (
      .clock      (clock),
      .resetb     (resetb),
      .cfg_enable (cfg_enable),
      .cfg_div    (cfg_div),
      .fb_tgl     (fb_tgl),
      .pll_resetb (pll_resetb),
      .pll_enable (pll_enable),
      .pll_div    (pll_div),
      .sel_pll    (sel_pll),
      .locked     (locked),
      .fail       (fail),
      .lock_lost  (lock_lost),
      .meas_cnt   (meas_cnt),
      .state      (state)
   );

   always #5 clock = ~clock;

   // {pll_resetb, pll_enable, sel_pll, locked, fail, lock_lost}
   assign flags = {pll_resetb, pll_enable, sel_pll, locked, fail, lock_lost};

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // One full window starting right after a window boundary; n edges, all well inside.
   task automatic run_window(input int n, input bit drop);
      int spacing;
      spacing = (n > 16) ? 14 : 16;
      for (int c = 0; c < 256; c++) begin
         for (int i = 0; i < n; i++) if (c == 4 + spacing * i) fb_tgl = ~fb_tgl;
         if (drop && c == 255) cfg_enable = 1'b0;
         step(1);
      end
   endtask

   task automatic bring_up(input logic [4:0] div);
      cfg_enable = 1'b1;
      cfg_div    = div;
      step(1041);
      tests++;
      if (state !== 3'd3) begin
         errors++; $display("FAIL bring_up_state got %0d want 3", state);
      end
   endtask

   task automatic test_reset;
      resetb = 1'b0; cfg_enable = 1'b0; cfg_div = 5'd0; fb_tgl = 1'b0;
      step(2);
      tests++;
      if (flags !== 6'b0 || state !== 3'd0 || meas_cnt !== 8'd0 || pll_div !== 5'd0) begin
         errors++;
         $display("FAIL reset_values got flags=%b st=%0d meas=%0d div=%0d want all 0",
                  flags, state, meas_cnt, pll_div);
      end
      resetb = 1'b1;
      step(5);
      tests++;
      if (state !== 3'd0 || flags !== 6'b0) begin
         errors++; $display("FAIL reset_idle got st=%0d flags=%b want 0", state, flags);
      end
   endtask

   task automatic test_nominal_lock;
      cfg_enable = 1'b1; cfg_div = 5'd8;
      step(16);
      tests++;
      if (state !== 3'd1 || flags !== 6'b010000 || pll_div !== 5'd8) begin
         errors++;
         $display("FAIL nom_reset_hold got st=%0d flags=%b div=%0d want 1 010000 8",
                  state, flags, pll_div);
      end
      step(1);
      tests++;
      if (state !== 3'd2 || flags !== 6'b110000) begin
         errors++; $display("FAIL nom_settle_entry got st=%0d flags=%b want 2 110000",
                            state, flags);
      end
      step(1023);
      tests++;
      if (state !== 3'd2) begin
         errors++; $display("FAIL nom_settle_end got st=%0d want 2", state);
      end
      step(1);
      tests++;
      if (state !== 3'd3) begin
         errors++; $display("FAIL nom_acquire_entry got st=%0d want 3", state);
      end
      for (int w = 0; w < 3; w++) begin
         run_window(16, 1'b0);
         tests++;
         if (state !== 3'd3 || locked !== 1'b0 || meas_cnt !== 8'd16) begin
            errors++; $display("FAIL nom_window%0d got st=%0d lk=%b meas=%0d want 3 0 16",
                               w, state, locked, meas_cnt);
         end
      end
      run_window(16, 1'b0);
      tests++;
      if (state !== 3'd4 || flags !== 6'b111100 || meas_cnt !== 8'd16 || pll_div !== 5'd8) begin
         errors++;
         $display("FAIL nom_locked got st=%0d flags=%b meas=%0d div=%0d want 4 111100 16 8",
                  state, flags, meas_cnt, pll_div);
      end
   endtask

   task automatic test_loss_of_lock;
      run_window(16, 1'b0);
      tests++;
      if (state !== 3'd4 || locked !== 1'b1) begin
         errors++; $display("FAIL lol_still_locked got st=%0d lk=%b want 4 1", state, locked);
      end
      run_window(0, 1'b0);
      tests++;
      if (state !== 3'd3 || flags !== 6'b110001 || meas_cnt !== 8'd0) begin
         errors++; $display("FAIL lol_drop got st=%0d flags=%b meas=%0d want 3 110001 0",
                            state, flags, meas_cnt);
      end
   endtask

   task automatic test_tolerance;
      int counts [7] = '{15, 17, 14, 15, 17, 16, 15};
      for (int w = 0; w < 6; w++) begin
         run_window(counts[w], 1'b0);
         tests++;
         if (state !== 3'd3 || meas_cnt !== 8'(counts[w])) begin
            errors++; $display("FAIL tol_window%0d got st=%0d meas=%0d want 3 %0d",
                               w, state, meas_cnt, counts[w]);
         end
      end
      run_window(counts[6], 1'b0);
      tests++;
      if (state !== 3'd4 || flags !== 6'b111101 || meas_cnt !== 8'd15) begin
         errors++; $display("FAIL tol_lock got st=%0d flags=%b meas=%0d want 4 111101 15",
                            state, flags, meas_cnt);
      end
   endtask

   task automatic test_reconfig;
      cfg_div = 5'd10;
      step(1);
      tests++;
      if (state !== 3'd1 || flags !== 6'b010000 || pll_div !== 5'd10) begin
         errors++; $display("FAIL reconf_entry got st=%0d flags=%b div=%0d want 1 010000 10",
                            state, flags, pll_div);
      end
      step(15);
      tests++;
      if (state !== 3'd1) begin
         errors++; $display("FAIL reconf_reset_hold got st=%0d want 1", state);
      end
      step(1);
      tests++;
      if (state !== 3'd2 || pll_resetb !== 1'b1) begin
         errors++; $display("FAIL reconf_settle got st=%0d rstb=%b want 2 1", state, pll_resetb);
      end
      step(1024);
      for (int w = 0; w < 4; w++) run_window(16, 1'b0);
      tests++;
      if (state !== 3'd4 || flags !== 6'b111100 || pll_div !== 5'd10) begin
         errors++; $display("FAIL reconf_lock got st=%0d flags=%b div=%0d want 4 111100 10",
                            state, flags, pll_div);
      end
   endtask

   task automatic test_async_reset;
      step(100);
      resetb = 1'b0;
      #2;
      tests++;
      if (flags !== 6'b0 || state !== 3'd0 || meas_cnt !== 8'd0 || pll_div !== 5'd0) begin
         errors++;
         $display("FAIL async_reset got flags=%b st=%0d meas=%0d div=%0d want all 0",
                  flags, state, meas_cnt, pll_div);
      end
      cfg_enable = 1'b0;
      step(1);
      resetb = 1'b1;
      step(3);
      tests++;
      if (state !== 3'd0 || flags !== 6'b0) begin
         errors++; $display("FAIL async_release got st=%0d flags=%b want 0", state, flags);
      end
   endtask

   task automatic test_timeout;
      bring_up(5'd10);
      step(63 * 256);
      tests++;
      if (state !== 3'd3 || fail !== 1'b0) begin
         errors++; $display("FAIL timeout_early got st=%0d fail=%b want 3 0", state, fail);
      end
      step(256);
      tests++;
      if (state !== 3'd5 || flags !== 6'b000010) begin
         errors++; $display("FAIL timeout_fail got st=%0d flags=%b want 5 000010", state, flags);
      end
      step(20);
      tests++;
      if (state !== 3'd5) begin
         errors++; $display("FAIL timeout_sticky got st=%0d want 5", state);
      end
      cfg_enable = 1'b0;
      step(1);
      tests++;
      if (state !== 3'd0 || flags !== 6'b0) begin
         errors++; $display("FAIL timeout_exit got st=%0d flags=%b want 0", state, flags);
      end
   endtask

   task automatic test_back_to_back;
      // Window end coincides with enable drop: IDLE, but the count still lands.
      bring_up(5'd8);
      run_window(12, 1'b1);
      tests++;
      if (state !== 3'd0 || flags !== 6'b0 || meas_cnt !== 8'd12) begin
         errors++; $display("FAIL drop_at_end got st=%0d flags=%b meas=%0d want 0 0 12",
                            state, flags, meas_cnt);
      end
      // Toggle every cycle so 256 edges fall in one window: count must clamp at 255.
      cfg_enable = 1'b1;
      step(1039);
      for (int k = 0; k < 258; k++) begin
         fb_tgl = ~fb_tgl;
         step(1);
      end
      tests++;
      if (state !== 3'd3 || meas_cnt !== 8'd255) begin
         errors++; $display("FAIL saturate got st=%0d meas=%0d want 3 255", state, meas_cnt);
      end
      cfg_enable = 1'b0;
      step(1);
      tests++;
      if (state !== 3'd0) begin
         errors++; $display("FAIL saturate_exit got st=%0d want 0", state);
      end
   endtask

   initial begin
      test_reset();
      test_nominal_lock();
      test_loss_of_lock();
      test_tolerance();
      test_reconfig();
      test_async_reset();
      test_timeout();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dpll_lock_sequencer.md
Name: dpll_lock_sequencer

Overview:
- Sequences power-up, lock qualification and clock switchover for the dpll instance.
- Runs on the reference oscillator clock. Drives dpll resetb/enable/div.
- Measures the PLL frequency from a toggle divided down in the PLL domain (÷16·div) and compares it against a fixed expected count.
- Asserts sel_pll, the glitch-free clock-mux select, only after the PLL is qualified; falls back to the reference on loss of lock.

Parameters:
- WIN_LOG2, 8: measurement window = 2^WIN_LOG2 clock cycles (256).
- FB_EXP, 16: expected fb_tgl edges per window when locked.
- FB_TOL, 1: accepted deviation, |cnt − FB_EXP| ≤ FB_TOL.
- RST_CYC, 16: cycles pll_resetb is held low in RESET.
- SETTLE_CYC, 1024: cycles after enable before the first window.
- LOCK_N, 4: consecutive good windows required to lock.
- MAX_TRY, 64: windows allowed in ACQUIRE before FAIL.

Ports:
- clock  in  1  reference oscillator clock (same net as dpll osc)
- resetb  in  1  asynchronous, active-low reset
- cfg_enable  in  1  request PLL operation
- cfg_div  in  5  requested feedback division ratio
- fb_tgl  in  1  PLL-domain toggle, one edge per 16·div PLL cycles (asynchronous)
- pll_resetb  out  1  to dpll resetb
- pll_enable  out  1  to dpll enable
- pll_div  out  5  to dpll div, latched copy of cfg_div
- sel_pll  out  1  clock-mux select, 1 = PLL clock
- locked  out  1  PLL qualified
- fail  out  1  acquisition timed out
- lock_lost  out  1  sticky, set on LOCKED→ACQUIRE; cleared on entry to RESET
- meas_cnt  out  8  last completed window count, saturating at 255
- state  out  3  current FSM state encoding

Behaviour:
- Reset values, all outputs: pll_resetb=0, pll_enable=0, pll_div=0, sel_pll=0, locked=0, fail=0, lock_lost=0, meas_cnt=0, state=IDLE. Synchroniser flops also reset to 0.
- fb_tgl path:
  - 2-flop synchroniser, then a third flop; edge = s2 XOR s3.
  - Edge pulse latency is 3 clocks after the fb_tgl transition.
- Window counter:
  - Free-runs only in ACQUIRE and LOCKED; cleared on entry to either state.
  - In the terminal cycle (count 2^WIN_LOG2−1), an edge in that same cycle is included.
  - meas_cnt ← final count; the edge counter clears; good = (|cnt−FB_EXP| ≤ FB_TOL).
- FSM states: IDLE=0, RESET=1, SETTLE=2, ACQUIRE=3, LOCKED=4, FAIL=5.
  - IDLE: all controls 0. When cfg_enable=1 → RESET; pll_div ← cfg_div; lock_lost ← 0.
  - RESET: pll_resetb=0, pll_enable=1 for RST_CYC cycles → SETTLE with pll_resetb=1.
  - SETTLE: counts SETTLE_CYC cycles → ACQUIRE. The good counter and try counter are cleared.
  - ACQUIRE, each window end:
    - good → good_cnt+1, else good_cnt ← 0.
    - try_cnt+1.
    - good_cnt reaching LOCK_N → LOCKED, locked=1, sel_pll=1 (registered, same edge).
    - Else try_cnt reaching MAX_TRY → FAIL.
  - LOCKED: measurement continues. On a bad window → ACQUIRE; locked=0, sel_pll=0, lock_lost=1; good_cnt and try_cnt cleared.
  - FAIL: fail=1, pll_enable=0, pll_resetb=0, sel_pll=0. Leaves only via cfg_enable=0.
- From any non-IDLE state:
  - cfg_enable=0 → IDLE next cycle; all controls drop in that cycle; fail cleared.
- cfg_div ≠ pll_div while in SETTLE, ACQUIRE or LOCKED:
  - → RESET; sel_pll and locked drop immediately; pll_div ← cfg_div.
  - cfg_enable=0 has priority over a div change.
- Simultaneous window end and cfg_enable drop: go to IDLE; meas_cnt still updates.
- fb counter saturates at 255, no wrap.

Decomposition:
- Package dpll_seq_pkg holds:
  - state encoding constants (3-bit);
  - default window, tolerance and timing constants.
- Sub-module dpll_freq_meter contains the synchroniser, edge detect, window counter and edge counter.
  - Outputs: win_done pulse, win_cnt[7:0].
  - Input: run (clears while low).
- The FSM, the good/try counters and the output registers live in the top block.

Test Plan:
- Reset: assert resetb=0 mid-LOCKED → all outputs 0, state=0, asynchronously. Release with cfg_enable=0 → stays IDLE.
- Nominal lock: cfg_enable=1, cfg_div=8, fb_tgl toggling every 16 clocks.
  - Expect pll_resetb rising 16 cycles after RESET entry, then SETTLE for 1024 cycles, then 4 windows.
  - Expect locked=sel_pll=1 at the end of the 4th window; meas_cnt=16; pll_div=8.
- Tolerance: window counts 15 and 17 are accepted. A count of 14 in window 3 → good_cnt resets, and lock happens 4 windows later.
- Loss of lock: stop fb_tgl while LOCKED → at the window end locked=0, sel_pll=0, lock_lost=1, meas_cnt=0, state=3.
- Timeout: fb_tgl static → after 64 windows fail=1, state=5, pll_enable=0. Then cfg_enable=0 → IDLE and fail=0.
- Reconfiguration: change cfg_div 8→10 while LOCKED → sel_pll=0 next cycle, state=RESET, pll_div=10, full re-sequence to lock.
